// File: rtl/stack_seq_pkg.sv
// Shared definitions for the 6809 push/pull sequencer: register codes, mask bits,
// byte-slot indices and the sequencer state encoding.
package stack_seq_pkg;

  localparam logic [3:0] RN_D  = 4'd0;
  localparam logic [3:0] RN_X  = 4'd1;
  localparam logic [3:0] RN_Y  = 4'd2;
  localparam logic [3:0] RN_U  = 4'd3;
  localparam logic [3:0] RN_S  = 4'd4;
  localparam logic [3:0] RN_PC = 4'd5;
  localparam logic [3:0] RN_A  = 4'd8;
  localparam logic [3:0] RN_B  = 4'd9;
  localparam logic [3:0] RN_CC = 4'd10;
  localparam logic [3:0] RN_DP = 4'd11;

  localparam int MB_PC = 7;
  localparam int MB_OS = 6;
  localparam int MB_Y  = 5;
  localparam int MB_X  = 4;
  localparam int MB_DP = 3;
  localparam int MB_B  = 2;
  localparam int MB_A  = 1;
  localparam int MB_CC = 0;

  localparam int NSLOT = 12;

  localparam logic [3:0] SL_PCL = 4'd0;
  localparam logic [3:0] SL_PCH = 4'd1;
  localparam logic [3:0] SL_OSL = 4'd2;
  localparam logic [3:0] SL_OSH = 4'd3;
  localparam logic [3:0] SL_YL  = 4'd4;
  localparam logic [3:0] SL_YH  = 4'd5;
  localparam logic [3:0] SL_XL  = 4'd6;
  localparam logic [3:0] SL_XH  = 4'd7;
  localparam logic [3:0] SL_DP  = 4'd8;
  localparam logic [3:0] SL_B   = 4'd9;
  localparam logic [3:0] SL_A   = 4'd10;
  localparam logic [3:0] SL_CC  = 4'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_e;

  // Slots are in push order; 16-bit registers occupy a low/high pair.
  function automatic logic [NSLOT-1:0] mask_to_slots(input logic [7:0] m);
    return {m[MB_CC], m[MB_A], m[MB_B], m[MB_DP], {2{m[MB_X]}}, {2{m[MB_Y]}},
            {2{m[MB_OS]}}, {2{m[MB_PC]}}};
  endfunction

  // Other-stack slots report RN_U; the top swaps in RN_S for U-stack ops.
  function automatic logic [3:0] slot_rn(input logic [3:0] s);
    case (s)
      SL_PCL, SL_PCH: return RN_PC;
      SL_OSL, SL_OSH: return RN_U;
      SL_YL, SL_YH:   return RN_Y;
      SL_XL, SL_XH:   return RN_X;
      SL_DP:          return RN_DP;
      SL_B:           return RN_B;
      SL_A:           return RN_A;
      SL_CC:          return RN_CC;
      default:        return RN_D;
    endcase
  endfunction

endpackage

// File: rtl/stack_seq_slot_pick.sv
// Combinational slot picker: lowest pending slot for push, highest for pull.
module stack_slot_pick
  import stack_seq_pkg::*;
(
  input  logic [NSLOT-1:0] pend,
  input  logic             pull,
  output logic [3:0]       slot,
  output logic [3:0]       rn,
  output logic             hi,
  output logic             none
);

  always_comb begin
    slot = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!pull && pend[i]) slot = 4'(i);
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (pull && pend[i]) slot = 4'(i);
    end
    none = ~|pend;
    hi   = (slot < SL_DP) && slot[0];
    rn   = slot_rn(slot);
  end

endmodule

// File: rtl/stack_seq.sv
// MC6809 PSHS/PSHU/PULS/PULU sequencer: walks the postbyte one byte per memory
// cycle, driving the register block ports and the byte-wide memory interface.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int USE_RDY = 1
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pull,
  input  logic        stack_s,
  input  logic [7:0]  mask,
  input  logic [15:0] reg_su,
  input  logic [15:0] path_data,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_data_i,
  output logic        busy,
  output logic        done,
  output logic        use_s,
  output logic [3:0]  reg_addr,
  output logic        dec_su,
  output logic        inc_su,
  output logic        write_reg,
  output logic [3:0]  write_reg_addr,
  output logic [15:0] data_w,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_o
);

  state_e           state_q, state_d;
  logic [NSLOT-1:0] pend_q, pend_d;
  logic             pull_q, pull_d;
  logic             use_s_q, use_s_d;
  logic [7:0]       hold_q, hold_d;

  logic       rdy;
  logic [3:0] pk_slot, pk_rn, rn_eff;
  logic       pk_hi, pk_none, wide;

  assign rdy = (USE_RDY != 0) ? mem_rdy : 1'b1;

  stack_slot_pick u_pick (
    .pend (pend_q),
    .pull (pull_q),
    .slot (pk_slot),
    .rn   (pk_rn),
    .hi   (pk_hi),
    .none (pk_none)
  );

  // The other stack is U for S-ops and S for U-ops.
  assign rn_eff = (pk_slot == SL_OSL || pk_slot == SL_OSH) ? (use_s_q ? RN_U : RN_S) : pk_rn;
  assign wide   = (pk_slot < SL_DP);

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_FIN);
  assign use_s = use_s_q;

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    pull_d         = pull_q;
    use_s_d        = use_s_q;
    hold_d         = hold_q;
    reg_addr       = '0;
    dec_su         = 1'b0;
    inc_su         = 1'b0;
    write_reg      = 1'b0;
    write_reg_addr = '0;
    data_w         = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_data_o     = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_d  = mask_to_slots(mask);
          pull_d  = pull;
          use_s_d = stack_s;
          state_d = (mask == 8'h00) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        mem_req  = 1'b1;
        mem_we   = ~pull_q;
        reg_addr = rn_eff;
        if (!pull_q) begin
          mem_addr   = reg_su - 16'd1;
          mem_data_o = pk_hi ? path_data[15:8] : path_data[7:0];
          dec_su     = rdy;
        end else begin
          mem_addr       = reg_su;
          inc_su         = rdy;
          write_reg_addr = rn_eff;
          data_w         = wide ? {hold_q, mem_data_i} : {8'h00, mem_data_i};
          write_reg      = rdy & ~pk_hi;
          if (rdy && pk_hi) hold_d = mem_data_i;
        end
        if (rdy) begin
          pend_d = pend_q & ~(NSLOT'(1) << pk_slot);
          if (pend_d == '0) state_d = ST_FIN;
        end
        if (pk_none) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      pull_q  <= 1'b0;
      use_s_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pull_q  <= pull_d;
      use_s_q <= use_s_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Push/pull sequencer for the MC6809 PSHS/PSHU/PULS/PULU instructions. It sits directly upstream of the dual-ported register block. It walks the 8-bit register-mask postbyte one byte per memory cycle, and for each byte it:
- drives the register block's left read address, write port and S/U increment/decrement strobes;
- issues byte-wide memory reads or writes at the current stack pointer.

The instruction sequencer hands it one start pulse and waits for `done`.

## Interface
Parameters:
- USE_RDY, default 1: when 0, `mem_rdy` is ignored and treated as 1.

Ports:
- clk_in  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; accepted only when busy=0
- pull  in  1  0 = push, 1 = pull; sampled with start
- stack_s  in  1  1 = S stack, 0 = U stack; sampled with start
- mask  in  8  postbyte; sampled with start. Bit7 PC, bit6 other stack (U for S-ops, S for U-ops), bit5 Y, bit4 X, bit3 DP, bit2 B, bit1 A, bit0 CC
- reg_su  in  16  current stack pointer from the register block
- path_data  in  16  register block left-path read data
- mem_rdy  in  1  memory completes the current byte this cycle
- mem_data_i  in  8  read data, valid when mem_rdy=1
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- use_s  out  1  stack select to register block (latched stack_s)
- reg_addr  out  4  RN_* code to register block left path
- dec_su, inc_su  out  1  stack pointer step strobes
- write_reg  out  1  register block write enable
- write_reg_addr  out  4  RN_* destination
- data_w  out  16  write data to register block
- mem_req, mem_we  out  1  memory request / write
- mem_addr  out  16  byte address
- mem_data_o  out  8  write data

## Operation
- Register codes: D=0, X=1, Y=2, U=3, S=4, PC=5, A=8, B=9, CC=10, DP=11.
- Byte slots, push order (slot 0 first): PCL, PCH, OSL, OSH, YL, YH, XL, XH, DP, B, A, CC. Pull uses the exact reverse order. A slot pair is taken only if its mask bit is set.
- States:
  - IDLE: start → RUN, or → FIN if mask=0. Latches mask, pull and stack_s into working registers.
  - RUN: per cycle, a combinational pick selects the lowest pending slot (push) or the highest pending slot (pull). On mem_rdy the slot clears. RUN → FIN when no slot remains after the clear.
  - FIN: done=1 for one cycle, then → IDLE.
- Push byte (in RUN):
  - mem_req=1, mem_we=1, mem_addr=reg_su−1 (16-bit wrap; 0x0000 → 0xFFFF).
  - reg_addr = slot register.
  - mem_data_o = path_data[15:8] for a high-byte slot, else path_data[7:0]. 8-bit registers use [7:0].
  - dec_su=mem_rdy.
- Pull byte (in RUN):
  - mem_req=1, mem_we=0, mem_addr=reg_su; inc_su=mem_rdy.
  - For a 16-bit high byte, mem_data_i is captured into a hold register and there is no register write.
  - For a 16-bit low byte: write_reg=mem_rdy, data_w={hold, mem_data_i}.
  - For an 8-bit register: write_reg=mem_rdy, data_w={8'h00, mem_data_i}.
- The "other stack" register is U (code 3) when stack_s=1 and S (code 4) when stack_s=0. The active stack pointer is therefore never a transfer target.
- A stall (mem_rdy=0) holds every output and all internal state; no strobes fire.

## Timing
- Reset values: busy, done, mem_req, mem_we, dec_su, inc_su and write_reg are 0. mem_addr, mem_data_o, data_w, reg_addr, write_reg_addr and use_s are 0. State is IDLE.
- If start is accepted at edge 0, bytes transfer in cycles 1..N (N = byte count) with mem_rdy=1. done=1 and busy=0 in cycle N+1. With mask=0, done=1 in cycle 1.
- busy=1 from cycle 1 through cycle N. start while busy=1 is ignored.
- Every strobe is combinational from state and mem_rdy; mem_data_o, mem_addr and data_w are valid in the same cycle.
- reset_n low mid-sequence returns the block to IDLE immediately. There is no rollback of the stack pointer or memory; partially pulled registers stay as written.

## Structure
- Shared defs file: the RN_* codes, mask bit positions, slot index constants (0–11) and state encoding.
- One sub-module, `stack_slot_pick`: combinational. Inputs are the 12-bit pending vector and pull; outputs are the slot index, RN code, high/low-byte flag and a none-left flag.

## Test plan
- PSHS mask 0xFF, S=0x0F00, PC=0x1234: 12 writes descending 0x0EFF..0x0EF4.
  - 0x0EFF=0x34, 0x0EFE=0x12, and CC lands last at 0x0EF4.
  - 12 dec_su pulses; done in cycle 13.
- PULU mask 0x06, U=0x0E00, mem[0x0E00]=0x12, mem[0x0E01]=0x34: A=0x12, B=0x34, U=0x0E02, done in cycle 3.
- PULS mask 0x10, mem[0x0F00]=0xAB, mem[0x0F01]=0xCD: exactly one write_reg, to code 1 with data_w=0xABCD.
- PSHS mask 0x02 with mem_rdy low for 3 cycles: outputs stable, no dec_su, then a single write on the 4th cycle; done in cycle 5.
- mask=0x00 start: done in cycle 1, no mem_req.
- reset_n asserted in cycle 2 of PSHS 0xFF: all outputs 0 immediately; a later start behaves normally.
